// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with mid-bit 3-sample majority vote, valid/ready output, framing and overrun flags
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state;
  logic s1, s2;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [1:0] smp;
  logic [DATA_BITS-1:0] shreg;
  logic vote, at_vote, at_end, take;
  assign vote = (smp[0] & smp[1]) | (smp[0] & s2) | (smp[1] & s2);
  assign at_vote = cnt == CW'(MID + 1);
  assign at_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign take = rx_valid && rx_ready;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      smp <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
      frame_err <= 1'b0;
      if (take) rx_valid <= 1'b0;
      cnt <= (state == IDLE || state == WAIT_IDLE || at_end) ? '0 : cnt + CW'(1);
      if (cnt == CW'(MID - 1)) smp[0] <= s2;
      if (cnt == CW'(MID)) smp[1] <= s2;
      case (state)
        IDLE: if (!s2) state <= START;
        START: begin
          if (at_vote && vote) state <= IDLE;
          else if (at_end) begin
            state <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (at_vote) shreg[bit_idx] <= vote;
          if (at_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        // Decide at the stop vote so the next start edge is never missed
        STOP: begin
          if (at_vote) begin
            if (vote) begin
              state <= IDLE;
              if (!rx_valid || take) begin
                rx_data <= shreg;
                rx_valid <= 1'b1;
              end else overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: if (s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: scoreboard bench for uart_rx_8n1 at 16 clocks per bit, 8 data bits
module tb_uart_rx_8n1;
  logic clk = 1'b0;
  logic rst, rx_in, rx_ready;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int vectors = 0, miscompares = 0;
  int cyc = 0, e_cyc = 0, last_rise = 0, rises = 0, ferrs = 0, busy_cycles = 0;
  int r0, f0;
  logic prev_valid = 1'b0;
  logic [7:0] sb[$];

  uart_rx_8n1 #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rises++;
      last_rise = cyc;
    end
    prev_valid = rx_valid;
    if (frame_err) ferrs++;
    if (busy) busy_cycles++;
    if (rx_valid && rx_ready) begin
      if (sb.size() == 0) check("unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
      else check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input bit push, input bit glitch);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    if (push) sb.push_back(d);
    e_cyc = cyc + 1;
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 16; k++) begin
        rx_in = (glitch && b > 0 && b < 9 && k == 9) ? ~f[b] : f[b];
        tick();
      end
  endtask

  initial begin
    logic [9:0] fr;
    rst = 1'b1;
    rx_in = 1'b1;
    rx_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (5) tick();
    // basic frame and exact latency
    r0 = rises;
    f0 = ferrs;
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    check("t1_latency", 32'(last_rise - e_cyc), 156);
    check("t1_rises", 32'(rises - r0), 1);
    check("t1_ferr", 32'(ferrs - f0), 0);
    check("t1_ovr", 32'(overrun), 0);
    check("t1_valid_1cyc", 32'(rx_valid), 0);
    // back-to-back with consumer stalled: second word dropped
    rx_ready = 1'b0;
    send(8'h00, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    check("t2_ovr", 32'(overrun), 1);
    check("t2_valid", 32'(rx_valid), 1);
    check("t2_held", 32'(rx_data), 32'h00);
    rx_ready = 1'b1;
    tick();
    check("t2_cleared", 32'(rx_valid), 0);
    check("t2_sb", 32'(sb.size()), 0);
    // false start
    r0 = rises;
    f0 = ferrs;
    busy_cycles = 0;
    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    repeat (30) tick();
    check("t3_busy_span", 32'(busy_cycles >= 8 && busy_cycles <= 12), 1);
    check("t3_rises", 32'(rises - r0), 0);
    check("t3_ferr", 32'(ferrs - f0), 0);
    check("t3_idle", 32'(busy), 0);
    // framing error followed by a long break
    r0 = rises;
    f0 = ferrs;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (640) tick();
    check("t4_ferr_once", 32'(ferrs - f0), 1);
    check("t4_wait_busy", 32'(busy), 1);
    check("t4_no_valid", 32'(rises - r0), 0);
    rx_in = 1'b1;
    repeat (8) tick();
    check("t4_idle", 32'(busy), 0);
    send(8'h55, 1'b1, 1'b1, 1'b0);
    check("t4_rises", 32'(rises - r0), 1);
    // one-cycle glitch at mid-bit in every data bit
    send(8'h96, 1'b1, 1'b1, 1'b1);
    check("t5_sb", 32'(sb.size()), 0);
    // reset during data bit 4
    fr = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 72; i++) begin
      rx_in = fr[i / 16];
      tick();
    end
    check("t6_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    rx_in = 1'b1;
    tick();
    check("t6_valid", 32'(rx_valid), 0);
    check("t6_data", 32'(rx_data), 0);
    check("t6_ferr", 32'(frame_err), 0);
    check("t6_ovr", 32'(overrun), 0);
    check("t6_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (32) tick();
    r0 = rises;
    send(8'h81, 1'b1, 1'b1, 1'b0);
    repeat (20) tick();
    check("t6_rises", 32'(rises - r0), 1);
    check("drain", 32'(sb.size()), 0);
    check("total_rises", 32'(rises), 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
